// File: rtl/Pipe_Buf_Reg_PKG.sv
// Shared pipeline-boundary types: stage-register structs and the skid-stage state encoding.
// Each pipeline boundary instantiates pipe_skid_stage with DATA_W = $bits(<struct>).
package Pipe_Buf_Reg_PKG;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_skid_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_wb_t;

    // The state encoding doubles as the entry count.
    function automatic logic [1:0] occupancy_of(input pipe_skid_state_e s);
        return s;
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One pipeline-boundary register with valid/ready handshake; SKID=1 adds a second entry
// so in_ready comes from a flop, SKID=0 is a single register with pass-through ready.
module pipe_skid_stage
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int DATA_W = 32,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pipe_skid_state_e  state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic              in_fire, out_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = occupancy_of(state_q);

    // NOTE: the payload register is reset as well, so out_data reads 0 while reset is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    if (SKID != 0) begin : g_skid

        logic [DATA_W-1:0] skid_q, skid_d;
        logic              in_ready_q, in_ready_d;

        // NOTE: every *_d starts from its current value so no path leaves it unassigned (no latch).
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    case ({in_fire, out_fire})
                        2'b11: main_d = in_data;
                        2'b10: begin
                            skid_d  = in_data;
                            state_d = FULL;
                        end
                        2'b01: state_d = EMPTY;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
            // Flush wins over every transfer; data registers keep stale, don't-care values.
            if (flush) begin
                state_d = EMPTY;
            end
            in_ready_d = (state_d != FULL);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                skid_q     <= '0;
                in_ready_q <= 1'b1;
            end else begin
                skid_q     <= skid_d;
                in_ready_q <= in_ready_d;
            end
        end

        assign in_ready = in_ready_q;

    end else begin : g_single

        // With one entry, a held payload can only be replaced in the cycle it leaves.
        assign in_ready = (state_q == EMPTY) | out_ready;

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire) begin
                        main_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                default: state_d = EMPTY;
            endcase
            if (flush) begin
                state_d = EMPTY;
            end
        end

    end

endmodule
